// File: rtl/microcode_sequencer.sv
// Programmable microcode sequencer: a writable dispatch table maps
// {class, sub-opcode} to an entry micro-PC, then consecutive microwords are
// issued one per cycle until an END word retires. WAIT words stall on ext_done.
module microcode_sequencer #(
    parameter int UCODE_WIDTH = 64,
    parameter int UADDR_WIDTH = 6,
    parameter int CLASS_WIDTH = 3,
    parameter int PROG_AW     = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inst_valid,
    output logic                   inst_ready,
    input  logic [CLASS_WIDTH-1:0] inst_class,
    input  logic [3:0]             inst_sub,
    output logic                   ctrl_valid,
    output logic [UCODE_WIDTH-3:0] ctrl_word,
    output logic [UADDR_WIDTH-1:0] upc,
    input  logic                   ext_done,
    input  logic                   abort,
    output logic                   seq_done,
    output logic                   seq_err,
    input  logic                   prog_we,
    input  logic                   prog_sel,
    input  logic [PROG_AW-1:0]     prog_addr,
    input  logic [UCODE_WIDTH-1:0] prog_data
);

    localparam int DEPTH      = 2 ** UADDR_WIDTH;
    localparam int DISP_AW    = CLASS_WIDTH + 4;
    localparam int DISP_DEPTH = 2 ** DISP_AW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [UADDR_WIDTH-1:0] upc_q, upc_d;

    // Contents are deliberately left unreset; software programs them first.
    logic [UCODE_WIDTH-1:0] ustore_mem   [DEPTH];
    logic [UADDR_WIDTH-1:0] dispatch_mem [DISP_DEPTH];

    logic [UCODE_WIDTH-1:0] cur_word_s;
    logic                   word_end_s;
    logic                   word_wait_s;
    logic                   accept_s;
    logic                   prog_wr_s;

    assign cur_word_s  = ustore_mem[upc_q];
    assign word_end_s  = cur_word_s[UCODE_WIDTH-1];
    assign word_wait_s = cur_word_s[UCODE_WIDTH-2];
    assign upc         = upc_q;

    // Next-state, micro-PC advance and per-cycle outputs.
    always_comb begin
        state_d    = state_q;
        upc_d      = upc_q;
        inst_ready = 1'b0;
        ctrl_valid = 1'b0;
        ctrl_word  = '0;
        seq_done   = 1'b0;
        seq_err    = 1'b0;
        accept_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                inst_ready = 1'b1;
                if (inst_valid) begin
                    accept_s = 1'b1;
                    upc_d    = dispatch_mem[{inst_class, inst_sub}];
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN, ST_HOLD: begin
                ctrl_valid = 1'b1;
                ctrl_word  = cur_word_s[UCODE_WIDTH-3:0];
                if (abort) begin
                    // Word is still visible this cycle, but its retirement is killed.
                    state_d = ST_IDLE;
                end else if (word_wait_s && !ext_done) begin
                    state_d = ST_HOLD;
                end else if (word_end_s) begin
                    seq_done = 1'b1;
                    state_d  = ST_IDLE;
                end else if (upc_q == {UADDR_WIDTH{1'b1}}) begin
                    // No wrap: running off the store is an error, not a loop.
                    seq_err = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    upc_d   = upc_q + UADDR_WIDTH'(1);
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Writes only land while idle and not colliding with an accept.
    assign prog_wr_s = rst_n & prog_we & (state_q == ST_IDLE) & ~accept_s;

    // State and micro-PC registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            upc_q   <= '0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
        end
    end

    // Microcode store and dispatch table write port.
    always_ff @(posedge clk) begin
        if (prog_wr_s) begin
            if (prog_sel) begin
                dispatch_mem[prog_addr[DISP_AW-1:0]] <= prog_data[UADDR_WIDTH-1:0];
            end else begin
                ustore_mem[prog_addr[UADDR_WIDTH-1:0]] <= prog_data;
            end
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed, table-driven bench for microcode_sequencer.
module tb_microcode_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid;
    logic        inst_ready;
    logic [2:0]  inst_class;
    logic [3:0]  inst_sub;
    logic        ctrl_valid;
    logic [61:0] ctrl_word;
    logic [5:0]  upc;
    logic        ext_done;
    logic        abort;
    logic        seq_done;
    logic        seq_err;
    logic        prog_we;
    logic        prog_sel;
    logic [6:0]  prog_addr;
    logic [63:0] prog_data;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [63:0] END_B  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] WAIT_B = 64'h4000_0000_0000_0000;

    always #5 clk = ~clk;

    microcode_sequencer dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_class(inst_class), .inst_sub(inst_sub), .ctrl_valid(ctrl_valid),
        .ctrl_word(ctrl_word), .upc(upc), .ext_done(ext_done), .abort(abort),
        .seq_done(seq_done), .seq_err(seq_err), .prog_we(prog_we), .prog_sel(prog_sel),
        .prog_addr(prog_addr), .prog_data(prog_data)
    );

    typedef struct {
        logic        iv;
        logic [2:0]  cls;
        logic [3:0]  sub;
        logic        ed;
        logic        ab;
        logic        rdy;
        logic        cv;
        logic [61:0] cw;
        logic        done;
        logic        err;
        int          upc;   // -1: micro-PC not checked this cycle
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t V(input logic iv, input logic [2:0] cls, input logic [3:0] sub,
                               input logic ed, input logic ab, input logic rdy, input logic cv,
                               input logic [61:0] cw, input logic done, input logic err,
                               input int u);
        vec_t v;
        v.iv = iv; v.cls = cls; v.sub = sub; v.ed = ed; v.ab = ab;
        v.rdy = rdy; v.cv = cv; v.cw = cw; v.done = done; v.err = err; v.upc = u;
        return v;
    endfunction

    task automatic chk(input string tag, input string what, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %h expected %h", tag, what, got, exp);
        end
    endtask

    // One cycle: drive after the edge, compare at the falling edge.
    task automatic apply(input vec_t v, input string tag);
        inst_valid = v.iv; inst_class = v.cls; inst_sub = v.sub;
        ext_done = v.ed; abort = v.ab;
        @(negedge clk);
        chk(tag, "inst_ready", 64'(inst_ready), 64'(v.rdy));
        chk(tag, "ctrl_valid", 64'(ctrl_valid), 64'(v.cv));
        chk(tag, "ctrl_word",  64'(ctrl_word),  64'(v.cw));
        chk(tag, "seq_done",   64'(seq_done),   64'(v.done));
        chk(tag, "seq_err",    64'(seq_err),    64'(v.err));
        if (v.upc >= 0) chk(tag, "upc", 64'(upc), 64'(v.upc));
        @(posedge clk); #1;
    endtask

    task automatic prog(input logic sel, input logic [6:0] addr, input logic [63:0] data);
        prog_we = 1'b1; prog_sel = sel; prog_addr = addr; prog_data = data;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    // Short helpers for frequently used vectors.
    function automatic vec_t IDLE_V(input int u);
        return V(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 62'h0, 1'b0, 1'b0, u);
    endfunction
    function automatic vec_t ACC(input logic [2:0] c, input logic [3:0] s, input logic ab, input int u);
        return V(1'b1, c, s, 1'b0, ab, 1'b1, 1'b0, 62'h0, 1'b0, 1'b0, u);
    endfunction
    function automatic vec_t ISS(input logic ed, input logic ab, input logic [61:0] cw,
                                 input logic done, input logic err, input int u);
        return V(1'b0, 3'd0, 4'h0, ed, ab, 1'b0, 1'b1, cw, done, err, u);
    endfunction

    initial begin
        rst_n = 1'b0; inst_valid = 1'b0; inst_class = 3'd0; inst_sub = 4'h0;
        ext_done = 1'b0; abort = 1'b0; prog_we = 1'b0; prog_sel = 1'b0;
        prog_addr = 7'd0; prog_data = 64'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state.
        apply(IDLE_V(0), "reset");

        // Program dispatch entries and microwords.
        prog(1'b1, 7'd0,  64'd5);                  // R ADD -> 5
        prog(1'b0, 7'd5,  64'h0A1);
        prog(1'b0, 7'd6,  END_B | 64'h0B2);
        prog(1'b1, 7'd34, 64'd10);                 // LOAD LW -> 10
        prog(1'b0, 7'd10, WAIT_B | 64'h011);
        prog(1'b0, 7'd11, END_B | 64'h022);
        prog(1'b1, 7'd16, 64'd63);                 // I sub0 -> 63
        prog(1'b0, 7'd63, 64'h03F);
        prog(1'b1, 7'd50, 64'd20);                 // STORE sub2 -> 20
        prog(1'b0, 7'd20, WAIT_B | END_B | 64'h033);
        prog(1'b1, 7'd32, 64'd10);                 // LOAD LB -> 10
        prog(1'b1, 7'd64, 64'd40);                 // BRANCH sub0 -> 40
        prog(1'b0, 7'd40, 64'h041);
        prog(1'b0, 7'd41, 64'h042);
        prog(1'b0, 7'd42, 64'h043);
        prog(1'b0, 7'd43, END_B | 64'h044);

        // ADD: two issue cycles, seq_done on the second.
        vecs.push_back(ACC(3'd0, 4'h0, 1'b0, 0));
        vecs.push_back(ISS(1'b0, 1'b0, 62'h0A1, 1'b0, 1'b0, 5));
        vecs.push_back(ISS(1'b0, 1'b0, 62'h0B2, 1'b1, 1'b0, 6));
        vecs.push_back(IDLE_V(-1));
        // LOAD: WAIT word held 4 cycles, retires on ext_done.
        vecs.push_back(ACC(3'd2, 4'h2, 1'b0, -1));
        for (int i = 0; i < 4; i++) vecs.push_back(ISS(1'b0, 1'b0, 62'h011, 1'b0, 1'b0, 10));
        vecs.push_back(ISS(1'b1, 1'b0, 62'h011, 1'b0, 1'b0, 10));
        vecs.push_back(ISS(1'b0, 1'b0, 62'h022, 1'b1, 1'b0, 11));
        vecs.push_back(IDLE_V(-1));
        // Overrun at the last store entry: error, no wrap.
        vecs.push_back(ACC(3'd1, 4'h0, 1'b0, -1));
        vecs.push_back(ISS(1'b0, 1'b0, 62'h03F, 1'b0, 1'b1, 63));
        vecs.push_back(IDLE_V(63));
        // WAIT+END in one word: stall first, then seq_done.
        vecs.push_back(ACC(3'd3, 4'h2, 1'b0, -1));
        vecs.push_back(ISS(1'b0, 1'b0, 62'h033, 1'b0, 1'b0, 20));
        vecs.push_back(ISS(1'b1, 1'b0, 62'h033, 1'b1, 1'b0, 20));
        vecs.push_back(IDLE_V(-1));
        // WAIT with ext_done already high retires without HOLD.
        vecs.push_back(ACC(3'd2, 4'h0, 1'b0, -1));
        vecs.push_back(ISS(1'b1, 1'b0, 62'h011, 1'b0, 1'b0, 10));
        vecs.push_back(ISS(1'b0, 1'b0, 62'h022, 1'b1, 1'b0, 11));
        vecs.push_back(IDLE_V(-1));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Abort on the 2nd word of a 4-word program.
        apply(ACC(3'd4, 4'h0, 1'b0, -1), "abort_acc");
        apply(ISS(1'b0, 1'b0, 62'h041, 1'b0, 1'b0, 40), "abort_w1");
        apply(ISS(1'b0, 1'b1, 62'h042, 1'b0, 1'b0, 41), "abort_w2");
        apply(IDLE_V(-1), "abort_idle");
        // Abort in IDLE is ignored; abort on an END word suppresses seq_done.
        apply(ACC(3'd0, 4'h0, 1'b1, -1), "abidle_acc");
        apply(ISS(1'b0, 1'b0, 62'h0A1, 1'b0, 1'b0, 5), "abend_w1");
        apply(ISS(1'b0, 1'b1, 62'h0B2, 1'b0, 1'b0, 6), "abend_w2");
        apply(IDLE_V(-1), "abend_idle");
        // Normal instruction after aborts.
        apply(ACC(3'd0, 4'h0, 1'b0, -1), "post_acc");
        apply(ISS(1'b0, 1'b0, 62'h0A1, 1'b0, 1'b0, 5), "post_w1");
        apply(ISS(1'b0, 1'b0, 62'h0B2, 1'b1, 1'b0, 6), "post_w2");
        apply(IDLE_V(-1), "post_idle");

        // Write during RUN is ignored.
        apply(ACC(3'd0, 4'h0, 1'b0, -1), "grun_acc");
        prog_we = 1'b1; prog_sel = 1'b0; prog_addr = 7'd5; prog_data = 64'hFFF;
        apply(ISS(1'b0, 1'b0, 62'h0A1, 1'b0, 1'b0, 5), "grun_w1");
        prog_we = 1'b0;
        apply(ISS(1'b0, 1'b0, 62'h0B2, 1'b1, 1'b0, 6), "grun_w2");
        apply(IDLE_V(-1), "grun_idle");
        apply(ACC(3'd0, 4'h0, 1'b0, -1), "grerun_acc");
        apply(ISS(1'b0, 1'b0, 62'h0A1, 1'b0, 1'b0, 5), "grerun_w1");
        apply(ISS(1'b0, 1'b0, 62'h0B2, 1'b1, 1'b0, 6), "grerun_w2");
        apply(IDLE_V(-1), "grerun_idle");
        // Write coincident with an accept is dropped.
        prog_we = 1'b1; prog_sel = 1'b0; prog_addr = 7'd5; prog_data = 64'hFFF;
        apply(ACC(3'd0, 4'h0, 1'b0, -1), "gcoin_acc");
        prog_we = 1'b0;
        apply(ISS(1'b0, 1'b0, 62'h0A1, 1'b0, 1'b0, 5), "gcoin_w1");
        apply(ISS(1'b0, 1'b0, 62'h0B2, 1'b1, 1'b0, 6), "gcoin_w2");
        apply(IDLE_V(-1), "gcoin_idle");

        // Reset while stalled in HOLD.
        apply(ACC(3'd2, 4'h2, 1'b0, -1), "rst_acc");
        apply(ISS(1'b0, 1'b0, 62'h011, 1'b0, 1'b0, 10), "rst_run");
        apply(ISS(1'b0, 1'b0, 62'h011, 1'b0, 1'b0, 10), "rst_hold");
        rst_n = 1'b0;
        apply(ISS(1'b0, 1'b0, 62'h011, 1'b0, 1'b0, 10), "rst_low");
        rst_n = 1'b1;
        apply(IDLE_V(0), "rst_after");
        apply(ACC(3'd2, 4'h2, 1'b0, 0), "rst_re_acc");
        apply(ISS(1'b1, 1'b0, 62'h011, 1'b0, 1'b0, 10), "rst_re_w1");
        apply(ISS(1'b0, 1'b0, 62'h022, 1'b1, 1'b0, 11), "rst_re_w2");
        apply(IDLE_V(-1), "rst_re_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Programmable, multi-step microcode sequencer for the microcoded memristor RISC-V core. It generalises the fixed single-word per-class ROMs into one writable microcode store plus a writable dispatch table.
- Each decoded instruction (class + sub-opcode) maps to an entry address. The block then steps a micro-PC through consecutive microwords, issuing one control word per cycle until a word with END set has issued.
- WAIT microwords stall until the memristor array / memory reports ext_done.
- Sits between the main decoder and the datapath/crossbar controller.

Parameters:
- UCODE_WIDTH, 64, microword width; bit [W-1]=END, bit [W-2]=WAIT, bits [W-3:0]=control field.
- UADDR_WIDTH, 6, micro-PC width; store depth = 2**UADDR_WIDTH.
- CLASS_WIDTH, 3, instruction-class width (R, I, LOAD, STORE, BRANCH, JUMP, LUI, spare).
- PROG_AW, 7, programming address width; must be >= max(UADDR_WIDTH, CLASS_WIDTH+4).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- inst_valid  in  1  decoded instruction offered.
- inst_ready  out  1  sequencer idle; accepts instruction.
- inst_class  in  CLASS_WIDTH  instruction class.
- inst_sub  in  4  sub-opcode: {funct7[5],funct3} for R; {0,funct3} otherwise; {000,isJALR} for jumps.
- ctrl_valid  out  1  ctrl_word is being issued this cycle.
- ctrl_word  out  UCODE_WIDTH-2  control field of the current microword; 0 when ctrl_valid=0.
- upc  out  UADDR_WIDTH  current micro-PC (debug).
- ext_done  in  1  external completion for WAIT words.
- abort  in  1  kill current sequence (flush/trap).
- seq_done  out  1  one-cycle pulse; END word retired.
- seq_err  out  1  one-cycle pulse; micro-PC overran the store.
- prog_we  in  1  write strobe for the stores.
- prog_sel  in  1  0 = microcode store, 1 = dispatch table.
- prog_addr  in  PROG_AW  store index; low bits are used.
- prog_data  in  UCODE_WIDTH  write data; dispatch uses low UADDR_WIDTH bits.

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n).
- Reset: state=IDLE, upc=0, inst_ready=1, ctrl_valid=0, ctrl_word=0, seq_done=0, seq_err=0. Store and dispatch contents are NOT reset; they must be programmed before use.
- States:
  - IDLE: inst_ready=1.
  - RUN: issuing words.
  - HOLD: WAIT word stalled.
- Accept: on an edge where inst_valid & inst_ready, upc <= dispatch[{inst_class,inst_sub}] and state <= RUN. The first control word appears the cycle after acceptance (latency 1). inst_ready=0 in RUN/HOLD.
- RUN/HOLD output: ctrl_valid=1 and ctrl_word=store[upc][W-3:0], combinational from the registered upc. In HOLD the same word is re-issued.
- Word retirement in a cycle:
  - WAIT=1 & ext_done=0 -> state HOLD, upc unchanged.
  - Otherwise, if END=1 -> seq_done=1 this cycle, state <= IDLE.
  - Otherwise, if upc == 2**UADDR_WIDTH-1 -> seq_err=1, state <= IDLE (no wrap).
  - Otherwise -> upc <= upc+1, state RUN.
- A WAIT word with ext_done already high retires in its first cycle (no HOLD).
- WAIT and END set in the same word: wait first, then retire with seq_done.
- abort in RUN/HOLD: state <= IDLE next edge. The current cycle still shows ctrl_valid, but seq_done/seq_err are suppressed. abort in IDLE has no effect.
- Back-to-back: seq_done cycle makes inst_ready=1 on the next cycle only. There is no same-cycle re-accept.
- Programming:
  - prog_we is honoured only in IDLE and only when not accepting that cycle; the write takes effect at the edge.
  - prog_we during RUN/HOLD is ignored.
  - If prog_we and inst_valid coincide in IDLE, the instruction is accepted and the write is dropped.
- Reset mid-sequence: abandons the sequence immediately and produces no seq_done.

Test Plan:
- Program dispatch[{3'd0,4'h0}]=5; store[5]=0x0000_0000_0000_00A1, store[6]=END|0x0B2. Accept ADD -> ctrl_word 0x0A1, then 0x0B2 with seq_done=1, inst_ready=1 on the next cycle; 2 issue cycles total.
- LOAD: store[10]=WAIT|0x11, store[11]=END|0x22. Hold ext_done=0 for 4 cycles -> 0x11 issued 5 cycles; raise ext_done -> 0x22 + seq_done.
- Overrun: entry 63 with store[63] lacking END -> one issue of store[63], seq_err=1, seq_done=0, returns to IDLE, upc not wrapped.
- abort asserted on the 2nd word of a 4-word program -> IDLE next cycle; no seq_done; a subsequent instruction is accepted normally.
- Programming guard: prog_we to store[5]=0xFFF during RUN -> store[5] unchanged on re-run. prog_we coincident with accepted inst_valid in IDLE -> write dropped.
- rst_n=0 during HOLD -> next cycle ctrl_valid=0, inst_ready=1, upc=0; previously programmed contents still run correctly afterwards.
